uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 74 +++++++
 tb/tb_uart_tx_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit framing FSM driving an external serializer, one bit per clk.
// Define UART_TX_PARITY_EN to compile in the optional parity slot (par_en/par_typ are otherwise ignored).
module uart_tx_ctrl #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic              ser_data,
  input  logic              ser_done,
  output logic              ser_en,
  output logic [DWIDTH-1:0] ser_p_data,
  output logic              tx_out,
  output logic              busy
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, next;
  logic   accept;
  assign accept = data_valid && (state == IDLE || state == STOP);
`ifdef UART_TX_PARITY_EN
  logic par_bit, par_act;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par_bit <= 1'b0;
      par_act <= 1'b0;
    end else if (accept) begin
      par_bit <= (^p_data) ^ par_typ;
      par_act <= par_en;
    end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_typ;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      ser_p_data <= '0;
    end else begin
      state <= next;
      if (accept) ser_p_data <= p_data;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? START : IDLE;
      START:   next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:    next = ser_done ? (par_act ? PARITY : STOP) : DATA;
      PARITY:  next = STOP;
`else
      DATA:    next = ser_done ? STOP : DATA;
`endif
      STOP:    next = accept ? START : IDLE;
      default: next = IDLE;
    endcase
  end
  assign busy   = (state != IDLE) && (state != STOP);
  assign ser_en = (state == START) || (state == DATA && !ser_done);
`ifdef UART_TX_PARITY_EN
  assign tx_out = (state == START)  ? 1'b0 :
                  (state == DATA)   ? ser_data :
                  (state == PARITY) ? par_bit : 1'b1;
`else
  assign tx_out = (state == START) ? 1'b0 :
                  (state == DATA)  ? ser_data : 1'b1;
`endif
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with a behavioural serializer stand-in.
module tb_uart_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       ser_data, ser_done, ser_en, tx_out, busy;
  logic [7:0] ser_p_data;
  int passed = 0;
  int total = 0;
  uart_tx_ctrl #(.DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .ser_data(ser_data), .ser_done(ser_done),
    .ser_en(ser_en), .ser_p_data(ser_p_data), .tx_out(tx_out), .busy(busy)
  );
  always #5 clk = ~clk;
  // serializer: loads on the first enabled edge, shifts LSB-first, flags the last bit
  logic [7:0] sh;
  logic [3:0] cnt;
  logic       act;
  assign ser_data = sh[0];
  assign ser_done = act && cnt == 4'd7;
  always @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0; cnt <= '0; act <= 1'b0;
    end else if (ser_en) begin
      if (!act) begin
        sh <= ser_p_data; cnt <= '0; act <= 1'b1;
      end else begin
        sh <= sh >> 1; cnt <= cnt + 4'd1;
      end
    end else if (ser_done) act <= 1'b0;
  task automatic test_idle(input string name);
    total++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0)
      $display("FAIL %s: tx_out=%b busy=%b ser_en=%b, required 1/0/0", name, tx_out, busy, ser_en);
    else passed++;
  endtask
  task automatic test_reset(input string name);
    total++;
    if (ser_p_data !== 8'h00) $display("FAIL %s ser_p_data: got %h, required 00", name, ser_p_data);
    else passed++;
    test_idle(name);
  endtask
  task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt, input bit pa, input bit keep);
    logic exp_tx, exp_en;
    int n;
    data_valid = 1'b1; p_data = d; par_en = pe; par_typ = pt;
    @(negedge clk);
    if (keep) p_data = ~d; else data_valid = 1'b0;
    par_en = ~pe; par_typ = ~pt;
    n = pa ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      exp_tx = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : (pa && i == 9) ? ((^d) ^ pt) : 1'b1;
      exp_en = (i >= 0 && i <= 7);
      total++;
      if (tx_out !== exp_tx) $display("FAIL frame %h tx_out[%0d]: got %b, required %b", d, i, tx_out, exp_tx);
      else passed++;
      total++;
      if (busy !== (i < n - 1)) $display("FAIL frame %h busy[%0d]: got %b, required %b", d, i, busy, i < n - 1);
      else passed++;
      total++;
      if (ser_en !== exp_en) $display("FAIL frame %h ser_en[%0d]: got %b, required %b", d, i, ser_en, exp_en);
      else passed++;
      if (i == 1) begin
        total++;
        if (ser_p_data !== d) $display("FAIL frame %h ser_p_data: got %h, required %h", d, ser_p_data, d);
        else passed++;
      end
    end
  endtask
  task automatic test_mid_frame_reset();
    data_valid = 1'b1; p_data = 8'h3C;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL pre-reset busy: got %b, required 1", busy);
    else passed++;
    rst = 1'b1;
    #1;
    test_reset("async reset mid-frame");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_idle("after mid-frame reset");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    test_idle("idle after release");
`ifdef UART_TX_PARITY_EN
    run_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    test_idle("idle after B2");
    run_frame(8'h83, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    test_idle("idle after 83 odd");
    run_frame(8'h83, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    run_frame(8'h83, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    @(negedge clk);
    test_idle("idle after 83");
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_idle("idle after back-to-back");
    test_mid_frame_reset();
    run_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_idle("idle after 0F");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
